// File: rtl/bp_pkg.sv
// bp_pkg: shared predictor mode constants, 2-bit counter encoding and its saturating update.
package bp_pkg;
   localparam int BP_STATIC  = 0;
   localparam int BP_BIMODAL = 1;
   localparam int BP_GSHARE  = 2;
   typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} sat2_t;
   function automatic sat2_t sat2_update(input sat2_t cnt, input logic taken);
      return taken ? (cnt == ST ? ST : sat2_t'(cnt + 2'd1)) : (cnt == SNT ? SNT : sat2_t'(cnt - 2'd1));
   endfunction
endpackage

// File: rtl/bp_btb.sv
// bp_btb: direct-mapped branch target buffer, combinational lookup and one write port.
module bp_btb #(
   parameter int IDX_W = 4,
   parameter int TAG_W = 26
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [IDX_W-1:0] rdIdx,
   input  logic [TAG_W-1:0] rdTag,
   output logic             rdHit,
   output logic [31:0]      rdTarget,
   input  logic             wrEn,
   input  logic [IDX_W-1:0] wrIdx,
   input  logic [TAG_W-1:0] wrTag,
   input  logic [31:0]      wrTarget
);
   localparam int N = 2**IDX_W;
   logic [N-1:0]     valid;
   logic [TAG_W-1:0] tags    [N];
   logic [31:0]      targets [N];
   // only valid bits need clearing; tag and target are don't-care while invalid
   always_ff @(posedge clk) begin
      if (reset) valid <= '0;
      else if (wrEn) begin
         valid[wrIdx]   <= 1'b1;
         tags[wrIdx]    <= wrTag;
         targets[wrIdx] <= wrTarget;
      end
   end
   assign rdHit    = valid[rdIdx] & (tags[rdIdx] == rdTag);
   assign rdTarget = rdHit ? targets[rdIdx] : '0;
endmodule

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: static/bimodal/gshare predictor with BTB and windowed branch statistics.
module branch_predict_unit
   import bp_pkg::*;
#(
   parameter int PRED_MODE = 1,
   parameter int IDX_W     = 6,
   parameter int BTB_IDX_W = 4,
   parameter int GHR_W     = 4,
   parameter int CNT_W     = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      iLookupPC,
   output logic             oPredTaken,
   output logic [31:0]      oPredTarget,
   output logic [IDX_W-1:0] oPredIndex,
   input  logic             iUpdValid,
   input  logic [31:0]      iUpdPC,
   input  logic [IDX_W-1:0] iUpdIndex,
   input  logic             iUpdTaken,
   input  logic [31:0]      iUpdTarget,
   input  logic             iUpdPredTaken,
   input  logic [31:0]      iUpdPredTarget,
   output logic             oMispredict,
   input  logic             iCountEn,
   output logic [CNT_W-1:0] oBranchCount,
   output logic [CNT_W-1:0] oMissCount
);
   localparam int TAG_W = 30 - BTB_IDX_W;
   localparam bit PREDICT = PRED_MODE != BP_STATIC;
   sat2_t            pht [2**IDX_W];
   logic [GHR_W-1:0] ghr;
   logic             btbHit;
   logic             tblWr;
   logic [1:0]       unusedBits;
   assign unusedBits = iLookupPC[1:0] ^ iUpdPC[1:0];
   assign oPredIndex = !PREDICT ? '0
                     : PRED_MODE == BP_GSHARE ? iLookupPC[IDX_W+1:2] ^ IDX_W'(ghr)
                     : iLookupPC[IDX_W+1:2];
   assign tblWr = iUpdValid & PREDICT;
   bp_btb #(.IDX_W(BTB_IDX_W), .TAG_W(TAG_W)) uBtb (
      .clk      (clk),
      .reset    (reset),
      .rdIdx    (iLookupPC[BTB_IDX_W+1:2]),
      .rdTag    (iLookupPC[31:BTB_IDX_W+2]),
      .rdHit    (btbHit),
      .rdTarget (oPredTarget),
      .wrEn     (tblWr & iUpdTaken),
      .wrIdx    (iUpdPC[BTB_IDX_W+1:2]),
      .wrTag    (iUpdPC[31:BTB_IDX_W+2]),
      .wrTarget (iUpdTarget)
   );
   assign oPredTaken  = PREDICT & btbHit & pht[oPredIndex][1];
   assign oMispredict = iUpdValid & ((iUpdTaken != iUpdPredTaken) | (iUpdTaken & (iUpdTarget != iUpdPredTarget)));
   // history is only committed at resolution, never speculatively at fetch
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 2**IDX_W; i++) pht[i] <= WNT;
         ghr <= '0;
      end else if (tblWr) begin
         pht[iUpdIndex] <= sat2_update(pht[iUpdIndex], iUpdTaken);
         if (PRED_MODE == BP_GSHARE) ghr <= GHR_W'({ghr, iUpdTaken});
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         oBranchCount <= '0;
         oMissCount   <= '0;
      end else if (iCountEn) begin
         if (iUpdValid & ~&oBranchCount) oBranchCount <= oBranchCount + 1'b1;
         if (oMispredict & ~&oMissCount) oMissCount <= oMissCount + 1'b1;
      end
   end
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: scoreboard bench driving a bimodal and a gshare instance side by side.
module tb_branch_predict_unit;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] iLookupPC = '0, iUpdPC = '0, iUpdTarget = '0;
   logic        iUpdValid = 1'b0, iUpdTaken = 1'b0, iCountEn = 1'b0;
   logic [5:0]  updIdxB = '0, updIdxG = '0;
   logic        upTB = 1'b0, upTG = 1'b0;
   logic [31:0] upTgtB = '0, upTgtG = '0;
   logic        tB, tG, missB, missG;
   logic [31:0] tgtB, tgtG, bcG, mcG;
   logic [5:0]  idxB, idxG;
   logic [2:0]  bcB, mcB;
   logic        selG = 1'b0;
   logic [31:0] oT, oTgt, oIdx, oMiss, oBc, oMc;
   typedef struct {string tag; logic [31:0] val;} exp_t;
   exp_t expQ[$];
   int checks = 0, failures = 0;

   always #5 clk = ~clk;

   branch_predict_unit #(.PRED_MODE(1), .IDX_W(6), .BTB_IDX_W(4), .GHR_W(4), .CNT_W(3)) dutB (
      .clk(clk), .reset(reset), .iLookupPC(iLookupPC), .oPredTaken(tB), .oPredTarget(tgtB),
      .oPredIndex(idxB), .iUpdValid(iUpdValid), .iUpdPC(iUpdPC), .iUpdIndex(updIdxB),
      .iUpdTaken(iUpdTaken), .iUpdTarget(iUpdTarget), .iUpdPredTaken(upTB),
      .iUpdPredTarget(upTgtB), .oMispredict(missB), .iCountEn(iCountEn),
      .oBranchCount(bcB), .oMissCount(mcB));

   branch_predict_unit #(.PRED_MODE(2), .IDX_W(6), .BTB_IDX_W(4), .GHR_W(2), .CNT_W(32)) dutG (
      .clk(clk), .reset(reset), .iLookupPC(iLookupPC), .oPredTaken(tG), .oPredTarget(tgtG),
      .oPredIndex(idxG), .iUpdValid(iUpdValid), .iUpdPC(iUpdPC), .iUpdIndex(updIdxG),
      .iUpdTaken(iUpdTaken), .iUpdTarget(iUpdTarget), .iUpdPredTaken(upTG),
      .iUpdPredTarget(upTgtG), .oMispredict(missG), .iCountEn(iCountEn),
      .oBranchCount(bcG), .oMissCount(mcG));

   always_comb begin
      oT    = {31'b0, selG ? tG : tB};
      oTgt  = selG ? tgtG : tgtB;
      oIdx  = {26'b0, selG ? idxG : idxB};
      oMiss = {31'b0, selG ? missG : missB};
      oBc   = selG ? bcG : {29'b0, bcB};
      oMc   = selG ? mcG : {29'b0, mcB};
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic push(input string tag, input logic [31:0] v);
      expQ.push_back('{tag, v});
   endtask

   task automatic pop(input logic [31:0] obs);
      exp_t e;
      if (expQ.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL sb_underflow got=%h exp=none", obs);
      end else begin
         e = expQ.pop_front();
         chk(e.tag, obs, e.val);
      end
   endtask

   task automatic doReset();
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic look(input string tag, input logic [31:0] pc, input logic expT, input logic [31:0] expTgt);
      @(negedge clk);
      iLookupPC = pc;
      push({tag, "_taken"}, {31'b0, expT});
      push({tag, "_target"}, expTgt);
      #1;
      pop(oT);
      pop(oTgt);
   endtask

   // fetch the branch first so each instance's own prediction travels with the update
   task automatic drvUpd(input logic [31:0] pc, input logic taken, input logic [31:0] target);
      iLookupPC = pc;
      #1;
      updIdxB = idxB; updIdxG = idxG;
      upTB = tB;      upTG = tG;
      upTgtB = tgtB;  upTgtG = tgtG;
      iUpdPC = pc; iUpdTaken = taken; iUpdTarget = target; iUpdValid = 1'b1;
      #1;
   endtask

   task automatic upd(input string tag, input logic [31:0] pc, input logic taken, input logic [31:0] target, input int expMiss);
      @(negedge clk);
      drvUpd(pc, taken, target);
      if (expMiss >= 0) begin
         push(tag, 32'(expMiss));
         pop(oMiss);
      end
      @(posedge clk);
      #1 iUpdValid = 1'b0;
   endtask

   task automatic counts(input string tag, input logic [31:0] b, input logic [31:0] m);
      @(negedge clk);
      push({tag, "_branches"}, b);
      push({tag, "_misses"}, m);
      pop(oBc);
      pop(oMc);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      doReset();
      look("t1", 32'h0040_0010, 1'b0, 32'h0);
      counts("t1", 0, 0);

      iCountEn = 1'b1;
      upd("t2_u1", 32'h20, 1'b1, 32'h40, 1);
      upd("t2_u2", 32'h20, 1'b1, 32'h40, 0);
      look("t2", 32'h20, 1'b1, 32'h40);
      push("t2_idx", 32'h8);
      pop(oIdx);
      counts("t2", 2, 1);

      for (int i = 0; i < 3; i++) upd("t3_t", 32'h20, 1'b1, 32'h40, 0);
      upd("t3_n1", 32'h20, 1'b0, 32'h0, 1);
      look("t3_n1", 32'h20, 1'b1, 32'h40);
      upd("t3_n2", 32'h20, 1'b0, 32'h0, 1);
      look("t3_n2", 32'h20, 1'b0, 32'h40);
      counts("t3", 7, 3);
      upd("t3_n3", 32'h20, 1'b0, 32'h0, 0);
      counts("t3_sat", 7, 3);

      iCountEn = 1'b0;
      doReset();
      upd("t4", 32'h20, 1'b1, 32'h40, -1);
      upd("t4", 32'h20, 1'b1, 32'h40, -1);
      upd("t4", 32'h60, 1'b1, 32'h80, -1);
      upd("t4", 32'h60, 1'b1, 32'h80, -1);
      look("t4_alias20", 32'h20, 1'b0, 32'h0);
      look("t4_alias60", 32'h60, 1'b1, 32'h80);
      upd("t4_tgtmiss", 32'h60, 1'b1, 32'h84, 1);
      look("t4_newtgt", 32'h60, 1'b1, 32'h84);
      counts("t4", 0, 0);

      doReset();
      upd("t5", 32'h20, 1'b1, 32'h40, -1);
      @(negedge clk);
      drvUpd(32'h20, 1'b0, 32'h0);
      push("t5_rdw_old", 1);
      pop(oT);
      @(posedge clk);
      #1 iUpdValid = 1'b0;
      push("t5_rdw_new", 0);
      pop(oT);
      iCountEn = 1'b1;
      @(negedge clk);
      drvUpd(32'h20, 1'b1, 32'h40);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      iUpdValid = 1'b0;
      look("t5_rst", 32'h20, 1'b0, 32'h0);
      counts("t5_rst", 0, 0);

      selG = 1'b1;
      iCountEn = 1'b0;
      doReset();
      @(negedge clk);
      iLookupPC = 32'h80;
      #1;
      push("t6_idx", 32'h20);
      pop(oIdx);
      iCountEn = 1'b1;
      for (int i = 0; i < 16; i++) upd("t6_miss", 32'h80, (i % 2) == 0, 32'h100, i >= 8 ? 0 : -1);
      counts("t6", 16, 2);
      iCountEn = 1'b0;
      upd("t6_frz_miss", 32'h80, 1'b1, 32'h200, 1);
      upd("t6_frz", 32'h80, 1'b0, 32'h0, -1);
      counts("t6_frz", 16, 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
